// File: rtl/riscv_defs_pkg.sv
// Shared definitions for the memory-access stage.
// Holds the access-size encodings, the misalignment exception causes, the bus FSM
// state encoding, and small helpers for lane selection and store-data replication.
package riscv_defs_pkg;

  localparam int unsigned XLEN = 32;

  // Access size as carried on load_store_size_in; 2'b11 behaves as a word.
  typedef enum logic [1:0] {
    SizeByte    = 2'b00,
    SizeHalf    = 2'b01,
    SizeWord    = 2'b10,
    SizeWordAlt = 2'b11
  } mem_size_e;

  localparam logic [3:0] EcauseLoadMisaligned  = 4'd4;
  localparam logic [3:0] EcauseStoreMisaligned = 4'd6;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } mem_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    case (mem_size_e'(size))
      SizeByte: mis = 1'b0;
      SizeHalf: mis = offset[0];
      default:  mis = |offset;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] be;
    case (mem_size_e'(size))
      SizeByte: be = 4'b0001 << offset;
      SizeHalf: be = 4'b0011 << offset;
      default:  be = 4'hF;
    endcase
    return be;
  endfunction

  // Replicate the store operand across all lanes so the bus can pick any lane by enable.
  function automatic logic [XLEN-1:0] store_replicate(input logic [1:0] size,
                                                      input logic [XLEN-1:0] data);
    logic [XLEN-1:0] rep;
    case (mem_size_e'(size))
      SizeByte: rep = {4{data[7:0]}};
      SizeHalf: rep = {2{data[15:0]}};
      default:  rep = data;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/memory_access_load_align.sv
// Combinational load alignment.
// Shifts the raw bus word right by the byte offset and sign/zero extends byte and half
// results. Word (and size 2'b11) results pass through unshifted.
// Ports:
//   data      in  32  raw word from the data bus
//   offset    in  2   byte offset of the access (addr[1:0])
//   size      in  2   access size encoding
//   is_signed in  1   sign-extend byte/half results
//   result    out 32  aligned, extended load value
module memory_access_load_align
  import riscv_defs_pkg::*;
(
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      offset,
  input  logic [1:0]      size,
  input  logic            is_signed,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = data >> {offset, 3'b000};
    case (mem_size_e'(size))
      SizeByte: result = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      SizeHalf: result = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default:  result = data;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage (between execute and writeback).
// Issues loads/stores on a request/ready data bus, flags misaligned accesses, stalls the
// pipeline while the bus is busy and registers the stage result for writeback.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   valid_in .. ecause_in       execute results and access controls
//   stall, invalidate           hazard-unit controls
//   *_in / *_out pass-through   pc, next_pc, csr_data, branch_taken, write_select,
//                               rd_address, csr_address, csr_write, mret, wfi, bypass_memory
//   mem_address .. mem_write    bus request (registered, held until mem_ready)
//   mem_ready, mem_load_data    bus completion and read data
//   mem_busy                    stage cannot accept/advance this cycle
//   alu_data_out .. ecause_out  registered stage result
module memory_access
  import riscv_defs_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [XLEN-1:0] alu_data_in,
  input  logic [XLEN-1:0] alu_addition_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic            load_in,
  input  logic            store_in,
  input  logic [1:0]      load_store_size_in,
  input  logic            load_signed_in,
  input  logic            exception_in,
  input  logic [3:0]      ecause_in,
  input  logic            stall,
  input  logic            invalidate,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] next_pc_in,
  input  logic [XLEN-1:0] csr_data_in,
  input  logic            branch_taken_in,
  input  logic [1:0]      write_select_in,
  input  logic [4:0]      rd_address_in,
  input  logic [11:0]     csr_address_in,
  input  logic            csr_write_in,
  input  logic            mret_in,
  input  logic            wfi_in,
  input  logic            bypass_memory_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] next_pc_out,
  output logic [XLEN-1:0] csr_data_out,
  output logic            branch_taken_out,
  output logic [1:0]      write_select_out,
  output logic [4:0]      rd_address_out,
  output logic [11:0]     csr_address_out,
  output logic            csr_write_out,
  output logic            mret_out,
  output logic            wfi_out,
  output logic            bypass_memory_out,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_store_data,
  output logic [3:0]      mem_byte_enable,
  output logic            mem_read,
  output logic            mem_write,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_load_data,
  output logic            mem_busy,
  output logic [XLEN-1:0] alu_data_out,
  output logic [XLEN-1:0] load_data_out,
  output logic            valid_out,
  output logic            exception_out,
  output logic [3:0]      ecause_out
);

  mem_state_e      state_q;
  logic [1:0]      req_offset_q;
  logic [1:0]      req_size_q;
  logic            req_signed_q;
  logic [XLEN-1:0] load_buf_q;
  // done_q: bus finished while stalled, result parked until the output register loads.
  logic            done_q;
  // kill_q: instruction was invalidated while its bus access was in flight.
  logic            kill_q;

  logic            mem_op;
  logic            misaligned;
  logic            mis_fault;
  logic            start;
  logic            complete;
  logic            hold;
  logic            exc_d;
  logic [3:0]      ecause_d;
  logic [XLEN-1:0] align_out;
  logic [XLEN-1:0] load_result;

  memory_access_load_align u_load_align (
    .data      (mem_load_data),
    .offset    (req_offset_q),
    .size      (req_size_q),
    .is_signed (req_signed_q),
    .result    (align_out)
  );

  always_comb begin
    mem_op     = load_in | store_in;
    misaligned = is_misaligned(load_store_size_in, alu_addition_in[1:0]);
    mis_fault  = valid_in & mem_op & misaligned & ~exception_in;
    start      = valid_in & mem_op & ~exception_in & ~misaligned & ~invalidate & ~done_q;
    complete   = (state_q == StWait) & mem_ready;
    mem_busy   = ((state_q == StIdle) & start) | ((state_q == StWait) & ~mem_ready);
    hold       = stall | mem_busy;

    exc_d    = exception_in | mis_fault;
    ecause_d = ecause_in;
    if (mis_fault) begin
      ecause_d = load_in ? EcauseLoadMisaligned : EcauseStoreMisaligned;
    end

    // Non-load results carry zero load data.
    load_result = '0;
    if (complete) begin
      load_result = mem_read ? align_out : '0;
    end else if (done_q) begin
      load_result = load_buf_q;
    end
  end

  // Bus FSM with registered request outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      mem_address     <= '0;
      mem_store_data  <= '0;
      mem_byte_enable <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      req_offset_q    <= '0;
      req_size_q      <= '0;
      req_signed_q    <= 1'b0;
      load_buf_q      <= '0;
      done_q          <= 1'b0;
      kill_q          <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            mem_address     <= {alu_addition_in[XLEN-1:2], 2'b00};
            mem_store_data  <= store_replicate(load_store_size_in, rs2_data_in);
            mem_byte_enable <= byte_enable(load_store_size_in, alu_addition_in[1:0]);
            mem_read        <= load_in;
            mem_write       <= store_in;
            req_offset_q    <= alu_addition_in[1:0];
            req_size_q      <= load_store_size_in;
            req_signed_q    <= load_signed_in;
            state_q         <= StWait;
          end
        end
        StWait: begin
          if (mem_ready) begin
            load_buf_q <= mem_read ? align_out : '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (complete && stall) begin
        done_q <= 1'b1;
      end else if (!hold) begin
        done_q <= 1'b0;
      end

      if (!hold) begin
        kill_q <= 1'b0;
      end else if (((state_q == StWait) || done_q) && invalidate) begin
        kill_q <= 1'b1;
      end
    end
  end

  // Stage output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out         <= 1'b0;
      alu_data_out      <= '0;
      load_data_out     <= '0;
      exception_out     <= 1'b0;
      ecause_out        <= '0;
      pc_out            <= '0;
      next_pc_out       <= '0;
      csr_data_out      <= '0;
      branch_taken_out  <= 1'b0;
      write_select_out  <= '0;
      rd_address_out    <= '0;
      csr_address_out   <= '0;
      csr_write_out     <= 1'b0;
      mret_out          <= 1'b0;
      wfi_out           <= 1'b0;
      bypass_memory_out <= 1'b0;
    end else begin
      valid_out <= (hold ? valid_out : (valid_in & ~kill_q)) & ~invalidate;
      if (!hold) begin
        alu_data_out      <= alu_data_in;
        load_data_out     <= load_result;
        exception_out     <= exc_d;
        ecause_out        <= ecause_d;
        pc_out            <= pc_in;
        next_pc_out       <= next_pc_in;
        csr_data_out      <= csr_data_in;
        branch_taken_out  <= branch_taken_in;
        write_select_out  <= write_select_in;
        rd_address_out    <= rd_address_in;
        csr_address_out   <= csr_address_in;
        csr_write_out     <= csr_write_in;
        mret_out          <= mret_in;
        wfi_out           <= wfi_in;
        bypass_memory_out <= bypass_memory_in;
      end
    end
  end

endmodule
